// File: rtl/ps2_rx_fifo_if.sv
// ps2_rx_fifo_if: PS/2 pins, pop/clear strobes and FIFO status for the PS/2 receive port.
interface ps2_rx_fifo_if #(parameter int DEPTH = 8);
  logic ps2_clk;
  logic ps2_data;
  logic rd;
  logic clr_err;
  logic [7:0] dato;
  logic vacio;
  logic lleno;
  logic [$clog2(DEPTH):0] count;
  logic error;
  logic ovf;
  modport master (
    output ps2_clk, ps2_data, rd, clr_err,
    input  dato, vacio, lleno, count, error, ovf
  );
  modport slave (
    input  ps2_clk, ps2_data, rd, clr_err,
    output dato, vacio, lleno, count, error, ovf
  );
endinterface

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 frame deserialiser feeding a show-ahead scan-code FIFO.
module ps2_rx_fifo #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 2000
) (
  input logic clk,
  input logic reset,
  ps2_rx_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t r_st;
  logic r_c1, r_c2, r_cp, r_d1, r_d2;
  logic [2:0] r_bit;
  logic [7:0] r_byte;
  logic r_perr;
  logic [TW-1:0] r_tmo;
  logic r_push;
  logic r_error, r_ovf;
  logic [7:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0] r_count;
  logic w_fe, w_empty, w_full, w_pop, w_acc;
  assign w_fe    = r_cp & ~r_c2;
  assign w_empty = r_count == '0;
  assign w_full  = r_count == (AW+1)'(DEPTH);
  assign w_pop   = bus.rd & ~w_empty;
  assign w_acc   = r_push & (~w_full | bus.rd);
  always_ff @(posedge clk) begin
    if (reset) begin
      {r_c1, r_c2, r_cp, r_d1, r_d2} <= '1;
      r_st    <= IDLE;
      r_bit   <= '0;
      r_tmo   <= '0;
      r_push  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      {r_c1, r_c2, r_cp} <= {bus.ps2_clk, r_c1, r_c2};
      {r_d1, r_d2} <= {bus.ps2_data, r_d1};
      r_push <= 1'b0;
      r_tmo <= (w_fe || r_st == IDLE) ? '0 : r_tmo + 1'b1;
      if (bus.clr_err) r_error <= 1'b0;
      if (r_st != IDLE && !w_fe && r_tmo == TW'(TIMEOUT)) r_st <= IDLE;
      else if (w_fe)
        case (r_st)
          IDLE: if (!r_d2) begin
            r_st  <= DATA;
            r_bit <= '0;
          end
          DATA: begin
            r_byte <= {r_d2, r_byte[7:1]};
            r_bit  <= r_bit + 1'b1;
            if (r_bit == 3'd7) r_st <= PARITY;
          end
          PARITY: begin
            r_perr <= ~(^r_byte ^ r_d2);
            r_st   <= STOP;
          end
          STOP: begin
            r_st <= IDLE;
            if (r_d2 && !r_perr) r_push <= 1'b1;
            else r_error <= 1'b1;
          end
        endcase
    end
  end
  // r_byte holds the completed frame until the next DATA bit, so the push can use it a cycle late
  always_ff @(posedge clk) begin
    if (w_acc) r_mem[r_wptr] <= r_byte;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_acc) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + (AW+1)'(w_acc) - (AW+1)'(w_pop);
      r_ovf   <= (r_push & ~w_acc) | (r_ovf & ~bus.clr_err);
    end
  end
  assign bus.dato  = w_empty ? 8'h00 : r_mem[r_rptr];
  assign bus.vacio = w_empty;
  assign bus.lleno = w_full;
  assign bus.count = r_count;
  assign bus.error = r_error;
  assign bus.ovf   = r_ovf;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: directed PS/2 frames against hand-computed FIFO contents and flags.
module tb_ps2_rx_fifo;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_err = 0;
  ps2_rx_fifo_if #(.DEPTH(8)) bus ();
  ps2_rx_fifo #(.DEPTH(8), .TIMEOUT(2000)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send_bit(input logic b);
    bus.ps2_data = b;
    tick(20);
    bus.ps2_clk = 1'b0;
    tick(20);
    bus.ps2_clk = 1'b1;
  endtask
  task automatic send_bits(input logic [7:0] b, input logic bad_par, input logic stop, input int n);
    logic [10:0] f;
    f = {stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < n; i++) send_bit(f[i]);
  endtask
  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop);
    send_bits(b, bad_par, stop, 11);
    tick(20);
  endtask
  task automatic pop;
    bus.rd = 1'b1;
    tick(1);
    bus.rd = 1'b0;
  endtask
  task automatic clear;
    bus.clr_err = 1'b1;
    tick(1);
    bus.clr_err = 1'b0;
  endtask
  task automatic chk_reset_state(input string tag);
    chk({tag, "_vacio"}, bus.vacio, 1);
    chk({tag, "_lleno"}, bus.lleno, 0);
    chk({tag, "_count"}, bus.count, 0);
    chk({tag, "_error"}, bus.error, 0);
    chk({tag, "_ovf"}, bus.ovf, 0);
    chk({tag, "_dato"}, bus.dato, 0);
  endtask
  initial begin
    bus.ps2_clk = 1'b1;
    bus.ps2_data = 1'b1;
    bus.rd = 1'b0;
    bus.clr_err = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(2);
    chk_reset_state("rst");
    // single byte with exact push latency
    send_bits(8'h1C, 1'b0, 1'b1, 10);
    bus.ps2_data = 1'b1;
    tick(20);
    bus.ps2_clk = 1'b0;
    tick(3);
    chk("lat_edge3_vacio", bus.vacio, 1);
    tick(1);
    chk("lat_edge4_vacio", bus.vacio, 0);
    tick(16);
    bus.ps2_clk = 1'b1;
    tick(20);
    chk("one_dato", bus.dato, 8'h1C);
    chk("one_count", bus.count, 1);
    chk("one_error", bus.error, 0);
    pop;
    chk("one_pop_vacio", bus.vacio, 1);
    chk("one_pop_dato", bus.dato, 0);
    // bad parity
    send_frame(8'h1C, 1'b1, 1'b1);
    chk("par_error", bus.error, 1);
    chk("par_count", bus.count, 0);
    clear;
    chk("par_clr", bus.error, 0);
    // bad stop bit
    send_frame(8'hF0, 1'b0, 1'b0);
    chk("stop_error", bus.error, 1);
    chk("stop_count", bus.count, 0);
    chk("stop_vacio", bus.vacio, 1);
    clear;
    // fill and overflow
    for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b0, 1'b1);
    chk("fill_lleno", bus.lleno, 1);
    chk("fill_count", bus.count, 8);
    chk("fill_ovf", bus.ovf, 0);
    send_frame(8'h09, 1'b0, 1'b1);
    chk("ovf_flag", bus.ovf, 1);
    chk("ovf_count", bus.count, 8);
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("drain_%0d", i), bus.dato, i);
      pop;
    end
    chk("drain_vacio", bus.vacio, 1);
    chk("drain_dato", bus.dato, 0);
    clear;
    chk("ovf_clr", bus.ovf, 0);
    // push into a full FIFO with a pop in the same cycle
    for (int i = 0; i < 8; i++) send_frame(8'h11 + 8'(i), 1'b0, 1'b1);
    send_bits(8'h19, 1'b0, 1'b1, 10);
    bus.ps2_data = 1'b1;
    tick(20);
    bus.ps2_clk = 1'b0;
    tick(3);
    bus.rd = 1'b1;
    tick(1);
    bus.rd = 1'b0;
    tick(16);
    bus.ps2_clk = 1'b1;
    tick(20);
    chk("sim_ovf", bus.ovf, 0);
    chk("sim_count", bus.count, 8);
    chk("sim_lleno", bus.lleno, 1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("sim_drain_%0d", i), bus.dato, 8'h12 + 8'(i));
      pop;
    end
    bus.rd = 1'b1;
    tick(2);
    bus.rd = 1'b0;
    chk("rd_empty_count", bus.count, 0);
    chk("rd_empty_dato", bus.dato, 0);
    // timeout abandons a partial frame
    send_bits(8'h3C, 1'b0, 1'b1, 5);
    tick(2100);
    send_frame(8'h5A, 1'b0, 1'b1);
    chk("tmo_count", bus.count, 1);
    chk("tmo_dato", bus.dato, 8'h5A);
    chk("tmo_error", bus.error, 0);
    pop;
    // reset mid-frame with data and error pending
    send_frame(8'h33, 1'b0, 1'b1);
    send_frame(8'h44, 1'b1, 1'b1);
    chk("pre_rst_count", bus.count, 1);
    chk("pre_rst_error", bus.error, 1);
    send_bits(8'h77, 1'b0, 1'b1, 4);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk_reset_state("midrst");
    tick(5);
    send_frame(8'h5A, 1'b0, 1'b1);
    chk("post_rst_count", bus.count, 1);
    chk("post_rst_dato", bus.dato, 8'h5A);
    chk("post_rst_error", bus.error, 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

Input peripheral that deserialises PS/2 keyboard frames and buffers the received scan-code bytes for the 8-bit datapath. It feeds one input port of the I/O read path: the processor polls `vacio`, reads `dato` through the 8-bit input multiplexer, and pops with `rd`. Frames with bad parity or a bad stop bit set a sticky error flag. Frames that arrive while the buffer is full are dropped and counted as overflow.

## Interface
- `DEPTH`, 8 — FIFO entries; power of two, 2..64.
- `TIMEOUT`, 2000 — clk cycles without a PS/2 falling edge before a partial frame is abandoned.
- `clk` in 1 — system clock; everything is rising-edge.
- `reset` in 1 — synchronous, active-high; one clock, synchronous active-high reset.
- `ps2_clk` in 1 — PS/2 clock; asynchronous to `clk`.
- `ps2_data` in 1 — PS/2 data; asynchronous to `clk`.
- `rd` in 1 — pop strobe; one pop per cycle asserted.
- `clr_err` in 1 — clears `error` and `ovf`.
- `dato` out 8 — head of FIFO (show-ahead); 8'h00 when empty.
- `vacio` out 1 — FIFO empty.
- `lleno` out 1 — FIFO full.
- `count` out log2(DEPTH)+1 — current occupancy.
- `error` out 1 — sticky parity/stop-bit error.
- `ovf` out 1 — sticky overflow: a valid byte was dropped because the FIFO was full.

## Operation
- **Synchroniser.** `ps2_clk` and `ps2_data` each pass through two flops (`s1`, `s2`).
  - A third flop holds the previous `s2` of clock.
  - A falling edge (`fe`) is `prev==1 && s2==0`; it lasts one cycle.
  - The data bit is sampled from synced data in the `fe` cycle.
- **FSM states: IDLE, DATA, PARITY, STOP.**
  - IDLE: on `fe` with data=0 (start bit), go to DATA with bitcnt=0. On `fe` with data=1, stay in IDLE (glitch, no flag).
  - DATA: on `fe`, shift right with the new bit into [7], so the byte ends LSB-first correct. After the 8th bit (bitcnt==7), go to PARITY.
  - PARITY: on `fe`, `perr = ~(^byte ^ bit)` (odd parity required), then go to STOP.
  - STOP: on `fe`, always return to IDLE.
    - bit=1 and perr=0: push the byte.
    - Otherwise: set `error`; nothing is pushed.
- **Timeout.** A cycle counter clears on every `fe` and in IDLE. If it reaches TIMEOUT in any non-IDLE state, return to IDLE and discard the partial frame. No flag is set.
- **FIFO.** Circular buffer with `wptr`, `rptr` and `count`.
  - Push is accepted if `count<DEPTH`, or if `count==DEPTH` and `rd` is high in the same cycle.
  - A push that is not accepted sets `ovf`.
  - `rd` while empty is ignored: pointers and count are unchanged and no flag is set.
  - Push and pop in the same cycle: both pointers advance and `count` is unchanged.
  - Pointers wrap modulo DEPTH.
  - `count` saturates at neither end; the rules above keep it in 0..DEPTH.
- **Flags.**
  - `vacio = (count==0)`, `lleno = (count==DEPTH)`.
  - `dato = vacio ? 0 : mem[rptr]`.
- **clr_err.** Clears `error` and `ovf` next edge. If an error or overflow event occurs in the same cycle, the set wins.

## Timing
- **Reset** (synchronous; takes effect on the rising edge with reset=1):
  - FSM to IDLE; pointers, count, bitcnt and the timeout counter to 0.
  - Synchroniser flops to 1.
  - `error`=0, `ovf`=0, `vacio`=1, `lleno`=0, `dato`=0.
  - FIFO contents are not cleared.
- **Reset mid-frame:** the frame is abandoned. Bits after reset release are interpreted from IDLE.
- **Edge latency:** a falling edge at the pin is seen as `fe` 3 clk edges later (two sync flops plus the prev flop).
- **Push latency:** the push occurs on the `fe` cycle of the stop bit. `vacio` falls, `count` increments and `dato` is valid on the following cycle.
- **Pop:** `rd` high at edge N pops the entry. The next entry (or 0) appears on `dato` after edge N; `count` decrements at the same edge.
- **PS/2 clock limit:** the PS/2 clock high and low phases must each be at least 3 clk cycles. Behaviour is undefined below that.

## Test plan
- **Single byte:** reset, then send frame 0x1C (start 0, bits LSB-first, parity 0, stop 1) with a 40-cycle PS/2 period. Required: `vacio` falls 4 edges after the stop falling edge, `dato`=0x1C, `count`=1, `error`=0. `rd` for one cycle gives `vacio`=1 and `dato`=0.
- **Bad parity:** send 0x1C with parity=1. Required: `error`=1, `count`=0. `clr_err` clears it one edge later.
- **Bad stop bit:** send 0xF0 with correct parity and stop=0. Required: `error`=1, nothing pushed.
- **Fill and overflow:** send DEPTH+1 bytes 0x01..0x09 with DEPTH=8.
  - Required after the 8th: `lleno`=1 and `count`=8.
  - Required after the 9th: `ovf`=1 and count still 8.
  - Popping 8 times returns 0x01..0x08 in order, with pointers wrapping.
- **Simultaneous events:**
  - FIFO full with `rd` asserted exactly in the stop-bit `fe` cycle: required `ovf`=0, count stays 8, and the new byte is last.
  - `rd` while empty: count stays 0.
- **Timeout and reset:**
  - Send start plus 4 bits, then idle TIMEOUT cycles. Required: FSM returns to IDLE, and a following full frame 0x5A is received correctly.
  - Assert `reset` mid-frame for 1 cycle. Required: all outputs at reset values, and the next full frame is received correctly.
